// File: rtl/subtrator_sequencial_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encodings
// and a helper that sizes the digit counter.
`ifndef SUBTRATOR_SEQUENCIAL_PKG_SV
`define SUBTRATOR_SEQUENCIAL_PKG_SV
package subtrator_sequencial_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Counter width for n digits; a single-digit configuration still gets one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`endif

// File: rtl/subtrator_digito.sv
// Combinational DIGIT-bit ripple subtractor (d = a - b - b_in) assembled from
// half/full subtractor cells. Every bit, the LSB included, is a full cell so
// the incoming borrow chains across successive digits.

module meio_subtrator (
   input  logic a,
   input  logic b,
   output logic d,
   output logic b_out
);
   assign d     = a ^ b;
   assign b_out = ~a & b;
endmodule

module subtrator_completo (
   input  logic a,
   input  logic b,
   input  logic b_in,
   output logic d,
   output logic b_out
);
   logic d1;
   logic bo1;
   logic bo2;

   meio_subtrator u_ms0 (.a(a),  .b(b),    .d(d1), .b_out(bo1));
   meio_subtrator u_ms1 (.a(d1), .b(b_in), .d(d),  .b_out(bo2));

   assign b_out = bo1 | bo2;
endmodule

module subtrator_digito #(
   parameter int DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             b_in,
   output logic [DIGIT-1:0] d,
   output logic             b_out
);
   logic [DIGIT:0] brw;

   assign brw[0] = b_in;

   genvar i;
   generate
      for (i = 0; i < DIGIT; i++) begin : g_bit
         subtrator_completo u_fs (
            .a     (a[i]),
            .b     (b[i]),
            .b_in  (brw[i]),
            .d     (d[i]),
            .b_out (brw[i+1])
         );
      end
   endgenerate

   assign b_out = brw[DIGIT];
endmodule

// File: rtl/subtrator_sequencial.sv
// Digit-serial subtractor: S = A - B - C_in, DIGIT bits per clock, LSB digit
// first, reusing a single DIGIT-bit subtractor. Result and flags appear
// together when the operation completes and hold until the next one.
module subtrator_sequencial
   import subtrator_sequencial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             V,
   output logic             Z
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(N - 1);

   logic [1:0]       estado;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic             borrow;

   int               base;
   logic [DIGIT-1:0] dig_d;
   logic             dig_bo;
   logic [WIDTH-1:0] res_next;

   assign base = int'(cnt) * DIGIT;

   subtrator_digito #(.DIGIT(DIGIT)) u_digito (
      .a     (a_reg[base +: DIGIT]),
      .b     (b_reg[base +: DIGIT]),
      .b_in  (borrow),
      .d     (dig_d),
      .b_out (dig_bo)
   );

   // Partial result with the current digit merged in; S is loaded from this on the last digit.
   always_comb begin
      res_next              = res_reg;
      res_next[base +: DIGIT] = dig_d;
   end

   // FSM, operand capture, digit iteration and the registered result/flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado  <= IDLE;
         cnt     <= '0;
         a_reg   <= '0;
         b_reg   <= '0;
         res_reg <= '0;
         borrow  <= 1'b0;
         S       <= '0;
         C_out   <= 1'b0;
         V       <= 1'b0;
         Z       <= 1'b0;
      end else begin
         case (estado)
            IDLE: begin
               if (start) begin
                  a_reg   <= A;
                  b_reg   <= B;
                  borrow  <= C_in;
                  cnt     <= '0;
                  res_reg <= '0;
                  estado  <= CALC;
               end
            end
            CALC: begin
               res_reg <= res_next;
               borrow  <= dig_bo;
               if (cnt == ULTIMO) begin
                  estado <= DONE;
                  S      <= res_next;
                  C_out  <= dig_bo;
                  V      <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                            (res_next[WIDTH-1] != a_reg[WIDTH-1]);
                  Z      <= ~|res_next;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    estado <= IDLE;
            default: estado <= IDLE;
         endcase
      end
   end

   assign busy = (estado != IDLE);
   assign done = (estado == DONE);

endmodule
